// File: rtl/eq_pkg.sv
// ============================================================================
//  eq_pkg
//  Shared widths, band count, mixer state encoding and saturation limits.
//  Revision: 1.0
// ============================================================================
`default_nettype none

package eq_pkg;

    localparam int WIDTH     = 16;
    localparam int FRAC_BITS = 8;
    localparam int N_BANDS   = 3;

    typedef enum logic [1:0] {
        ACCUM = 2'd0,
        DRAIN = 2'd1,
        OUT   = 2'd2
    } state_t;

    localparam logic [WIDTH-1:0] MAX = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] MIN = {1'b1, {(WIDTH-1){1'b0}}};

endpackage

`default_nettype wire

// File: rtl/sat_mul.sv
// ============================================================================
//  sat_mul
//  Combinational signed fixed-point multiply: full product, floor shift by
//  FracBits, saturate to Width with an overflow indicator.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module sat_mul
    import eq_pkg::*;
#(
    parameter int Width    = WIDTH,
    parameter int FracBits = FRAC_BITS
) (
    input  logic [Width-1:0] i_a,
    input  logic [Width-1:0] i_b,
    output logic [Width-1:0] o_p,
    output logic             o_sat
);

    localparam logic [Width-1:0] c_max = {1'b0, {(Width-1){1'b1}}};
    localparam logic [Width-1:0] c_min = {1'b1, {(Width-1){1'b0}}};

    logic signed [2*Width-1:0] w_prod;
    logic signed [2*Width-1:0] w_shift;
    logic                      w_pos_ovf;
    logic                      w_neg_ovf;

    assign w_prod  = $signed(i_a) * $signed(i_b);
    assign w_shift = w_prod >>> FracBits;

    // Result fits only when every bit above the output sign bit matches it.
    assign w_pos_ovf = !w_shift[2*Width-1] &&  (|w_shift[2*Width-2:Width-1]);
    assign w_neg_ovf =  w_shift[2*Width-1] && !(&w_shift[2*Width-2:Width-1]);

    assign o_p   = w_pos_ovf ? c_max :
                   w_neg_ovf ? c_min : w_shift[Width-1:0];
    assign o_sat = w_pos_ovf | w_neg_ovf;

endmodule

`default_nettype wire

// File: rtl/band_mixer.sv
// ============================================================================
//  band_mixer
//  Gains Bands signed samples, sums them with saturation and presents one
//  mixed frame per handshake. Define BAND_MIXER_SAT_FLAG_EN for sat_flag.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module band_mixer
    import eq_pkg::*;
#(
    parameter int Width    = WIDTH,
    parameter int FracBits = FRAC_BITS,
    parameter int Bands    = N_BANDS
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [Width-1:0] in_sample,
    input  logic [Width-1:0] in_gain,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [Width-1:0] out_sample,
    output logic             sat_flag
);

    localparam int               c_cnt_w = (Bands > 1) ? $clog2(Bands) : 1;
    localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(Bands - 1);
    localparam logic [Width-1:0] c_max = {1'b0, {(Width-1){1'b1}}};
    localparam logic [Width-1:0] c_min = {1'b1, {(Width-1){1'b0}}};

    state_t               r_state;
    state_t               w_state_next;
    logic                 r_armed;
    logic [c_cnt_w-1:0]   r_cnt;
    logic [Width-1:0]     r_prod;
    logic                 r_prod_valid;
    logic [Width-1:0]     r_acc;

    logic [Width-1:0]     w_mul_p;
    logic                 w_mul_sat;
    logic                 w_accept;
    logic                 w_last;
    logic                 w_done;
    logic [Width-1:0]     w_sum;
    logic                 w_acc_pos_ovf;
    logic                 w_acc_neg_ovf;
    logic                 w_acc_ovf;
    logic [Width-1:0]     w_acc_next;

    sat_mul #(
        .Width    (Width),
        .FracBits (FracBits)
    ) u_sat_mul (
        .i_a   (in_sample),
        .i_b   (in_gain),
        .o_p   (w_mul_p),
        .o_sat (w_mul_sat)
    );

    assign w_accept = in_valid && (r_state == ACCUM) && r_armed;
    assign w_last   = (r_cnt == c_last);
    assign w_done   = (r_state == OUT) && out_ready;

    assign w_sum         = r_acc + r_prod;
    assign w_acc_pos_ovf = !r_acc[Width-1] && !r_prod[Width-1] &&  w_sum[Width-1];
    assign w_acc_neg_ovf =  r_acc[Width-1] &&  r_prod[Width-1] && !w_sum[Width-1];
    assign w_acc_ovf     = w_acc_pos_ovf || w_acc_neg_ovf;
    assign w_acc_next    = w_acc_pos_ovf ? c_max :
                           w_acc_neg_ovf ? c_min : w_sum;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ACCUM;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        in_ready     = 1'b0;
        out_valid    = 1'b0;
        case (r_state)
            ACCUM: begin
                in_ready = r_armed;
                if (w_accept && w_last) begin
                    w_state_next = DRAIN;
                end
            end
            DRAIN: begin
                w_state_next = OUT;
            end
            OUT: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    w_state_next = ACCUM;
                end
            end
            default: begin
                w_state_next = ACCUM;
            end
        endcase
    end

    // r_armed keeps in_ready low until the first edge after reset releases.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_armed      <= 1'b0;
            r_cnt        <= '0;
            r_prod       <= '0;
            r_prod_valid <= 1'b0;
            r_acc        <= '0;
        end else begin
            r_armed      <= 1'b1;
            r_prod_valid <= w_accept;
            if (w_accept) begin
                r_prod <= w_mul_p;
            end
            if (w_done) begin
                r_cnt <= '0;
            end else if (w_accept) begin
                r_cnt <= r_cnt + c_cnt_w'(1);
            end
            if (w_done) begin
                r_acc <= '0;
            end else if (r_prod_valid) begin
                r_acc <= w_acc_next;
            end
        end
    end

    assign out_sample = out_valid ? r_acc : '0;

`ifdef BAND_MIXER_SAT_FLAG_EN
    logic r_prod_sat;
    logic r_sat;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_prod_sat <= 1'b0;
            r_sat      <= 1'b0;
        end else begin
            if (w_accept) begin
                r_prod_sat <= w_mul_sat;
            end
            if (w_done) begin
                r_sat <= 1'b0;
            end else if (r_prod_valid && (r_prod_sat || w_acc_ovf)) begin
                r_sat <= 1'b1;
            end
        end
    end

    assign sat_flag = r_sat;
`else
    logic w_unused_sat;
    assign w_unused_sat = w_mul_sat;
    assign sat_flag     = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_band_mixer.sv
// ============================================================================
//  tb_band_mixer
//  Directed self-checking bench for band_mixer (Width=16, FracBits=8, Bands=3).
//  Revision: 1.0
// ============================================================================
`default_nettype none

module tb_band_mixer;

`ifdef BAND_MIXER_SAT_FLAG_EN
    localparam logic c_sat_exp = 1'b1;
`else
    localparam logic c_sat_exp = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] in_sample = '0;
    logic [15:0] in_gain = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] out_sample;
    logic        sat_flag;

    int errors = 0;
    int checks = 0;

    band_mixer dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_sample  (in_sample),
        .in_gain    (in_gain),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_sample (out_sample),
        .sat_flag   (sat_flag)
    );

    always #5 clk = ~clk;

    // Presents one band at a negedge; it is taken at the following posedge.
    task automatic push(input logic [15:0] s, input logic [15:0] g);
        int n;
        n = 0;
        while (!in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        in_valid  = 1'b1;
        in_sample = s;
        in_gain   = g;
        @(negedge clk);
        in_valid  = 1'b0;
    endtask

    task automatic wait_out();
        int n;
        n = 0;
        while (!out_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic consume();
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready: got %b want 0", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        checks++; if (out_sample !== 16'h0000) begin errors++; $display("FAIL reset_out_sample: got %0d want 0", $signed(out_sample)); end
        checks++; if (sat_flag !== 1'b0) begin errors++; $display("FAIL reset_sat_flag: got %b want 0", sat_flag); end
        reset = 1'b0;
        @(negedge clk);
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_release_ready: got %b want 1", in_ready); end
    endtask

    task automatic test_back_to_back();
        push(16'd1000, 16'h0100);
        push(16'd2000, 16'h0100);
        push(16'd3000, 16'h0100);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_drain_valid: got %b want 0", out_valid); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL b2b_drain_ready: got %b want 0", in_ready); end
        @(negedge clk);
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL b2b_out_valid: got %b want 1", out_valid); end
        checks++; if (out_sample !== 16'd6000) begin errors++; $display("FAIL b2b_out_sample: got %0d want 6000", $signed(out_sample)); end
        checks++; if (sat_flag !== 1'b0) begin errors++; $display("FAIL b2b_sat_flag: got %b want 0", sat_flag); end
        consume();
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL b2b_after_handshake: got valid=%b ready=%b want valid=0 ready=1", out_valid, in_ready); end
    endtask

    task automatic test_pos_sat();
        push(16'd20000, 16'h0100);
        push(16'd20000, 16'h0100);
        push(16'd0, 16'h0100);
        wait_out();
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL pos_sat_valid: got %b want 1", out_valid); end
        checks++; if (out_sample !== 16'h7FFF) begin errors++; $display("FAIL pos_sat_sample: got %0d want 32767", $signed(out_sample)); end
        checks++; if (sat_flag !== c_sat_exp) begin errors++; $display("FAIL pos_sat_flag: got %b want %b", sat_flag, c_sat_exp); end
        consume();
    endtask

    task automatic test_neg_sat();
        push(16'h8000, 16'h0200);
        push(-16'sd100, 16'h0100);
        push(-16'sd100, 16'h0100);
        wait_out();
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL neg_sat_valid: got %b want 1", out_valid); end
        checks++; if (out_sample !== 16'h8000) begin errors++; $display("FAIL neg_sat_sample: got %0d want -32768", $signed(out_sample)); end
        checks++; if (sat_flag !== c_sat_exp) begin errors++; $display("FAIL neg_sat_flag: got %b want %b", sat_flag, c_sat_exp); end
        consume();
    endtask

    task automatic test_floor();
        push(-16'sd3, 16'h0080);
        push(16'd0, 16'h0100);
        push(16'd0, 16'h0100);
        wait_out();
        checks++; if (out_sample !== 16'hFFFE) begin errors++; $display("FAIL floor_sample: got %0d want -2", $signed(out_sample)); end
        checks++; if (sat_flag !== 1'b0) begin errors++; $display("FAIL floor_sat_flag: got %b want 0", sat_flag); end
        consume();
    endtask

    task automatic test_backpressure();
        push(16'd1, 16'h0100);
        push(16'd2, 16'h0100);
        push(16'd3, 16'h0100);
        wait_out();
        in_valid  = 1'b1;
        in_sample = 16'd7;
        in_gain   = 16'h0100;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++; if (out_valid !== 1'b1 || out_sample !== 16'd6 || in_ready !== 1'b0) begin
                errors++;
                $display("FAIL hold_cycle%0d: got valid=%b sample=%0d ready=%b want valid=1 sample=6 ready=0", i, out_valid, $signed(out_sample), in_ready);
            end
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL release_ready: got %b want 1", in_ready); end
        @(negedge clk);
        in_valid = 1'b0;
        push(16'd8, 16'h0100);
        push(16'd9, 16'h0100);
        wait_out();
        checks++; if (out_sample !== 16'd24) begin errors++; $display("FAIL release_frame: got %0d want 24", $signed(out_sample)); end
        consume();
    endtask

    task automatic test_reset_mid_frame();
        push(16'd5, 16'h0100);
        push(16'd6, 16'h0100);
        reset = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b0 || out_valid !== 1'b0 || out_sample !== 16'h0000 || sat_flag !== 1'b0) begin
            errors++;
            $display("FAIL midreset_outputs: got ready=%b valid=%b sample=%0d sat=%b want all 0", in_ready, out_valid, $signed(out_sample), sat_flag);
        end
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        push(16'd10, 16'h0100);
        push(16'd20, 16'h0100);
        push(16'd30, 16'h0100);
        wait_out();
        checks++; if (out_valid !== 1'b1 || out_sample !== 16'd60) begin errors++; $display("FAIL midreset_frame: got valid=%b sample=%0d want valid=1 sample=60", out_valid, $signed(out_sample)); end
        consume();
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_pos_sat();
        test_neg_sat();
        test_floor();
        test_backpressure();
        test_reset_mid_frame();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
